ghost_dist_map_writer: RTL and testbench
========================================

Name: ghost_dist_map_writer

Overview:
- Write-side producer for the ghost proximity map. The ghost location controller reads this map to choose each ghost's next step.
- Sweeps every grid cell and writes an 8-bit cost into the map RAM write port. Cost is the Manhattan distance to pacman, plus a penalty on each ghost's previous cell, with walls forced to the maximum value.
- Asserts ready only while the stored map matches the current pacman and ghost positions.
- Sits between the maze wall ROM and the dual-port ghost map RAM.

Parameters:
- COLS, 40, grid width in cells (x range 0..COLS-1).
- ROWS, 30, grid height in cells (y range 0..ROWS-1).
- WALL_VAL, 255, cost written for wall cells.
- PREV_PENALTY, 8, cost added at either ghost's previous cell (discourages reversing).

Ports:
- CLOCK_50  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  single-cycle pulse forcing a map rebuild.
- curr_pacman_x  input  6  pacman column.
- curr_pacman_y  input  5  pacman row.
- prev_ghost1_x / prev_ghost1_y  input  6 / 5  ghost1 previous cell.
- prev_ghost2_x / prev_ghost2_y  input  6 / 5  ghost2 previous cell.
- wall_rdaddr_x / wall_rdaddr_y  output  6 / 5  wall ROM read address.
- wall_q  input  1  wall ROM data, valid exactly 1 cycle after its address; 1 = wall.
- wren  output  1  map RAM write enable.
- wraddr_x / wraddr_y  output  6 / 5  map RAM write address.
- wrdata  output  8  map cost value.
- ready  output  1  map is complete and consistent.
- map_done  output  1  one-cycle pulse when a sweep finishes.

Behaviour:
- Reset (reset=0, async):
  - State is IDLE; ready=0, map_done=0, wren=0, all addresses and wrdata = 0.
  - pending=1; snapshot registers are cleared.
  - Any in-progress sweep is abandoned.
- States and transitions:
  - IDLE -> SWEEP on the next edge when pending=1.
  - SWEEP -> DRAIN after the address for cell (COLS-1, ROWS-1) is issued.
  - DRAIN -> IDLE.
- Snapshot: on the edge entering SWEEP, latch curr_pacman, prev_ghost1, prev_ghost2. On the same edge set pending=0 and ready=0.
- Pending set: pending=1 whenever start=1, or when any of the five live position inputs differs from its snapshot. This is checked every cycle in IDLE, SWEEP and DRAIN.
- SWEEP cycle k (k = 0..COLS*ROWS-1):
  - Drive wall_rdaddr = (x_cnt, y_cnt).
  - x_cnt counts 0..COLS-1 and wraps to 0 while incrementing y_cnt.
  - Cell 0 is (0,0); the last cell is (COLS-1, ROWS-1).
- Write stage (one cycle behind the read):
  - The registered address from the previous cycle is used together with wall_q.
  - wren=1; wraddr = that address; wrdata = cost. wren is high in SWEEP cycles 1..N-1 and in DRAIN (N = COLS*ROWS).
- Cost, all computed on the snapshot:
  - d = |x - px| + |y - py|, unsigned, 8-bit.
  - Add PREV_PENALTY for each ghost whose previous cell equals (x,y). Both ghosts matching the same cell adds 2*PREV_PENALTY.
  - Saturate the result at 254.
  - If wall_q=1, cost = WALL_VAL, overriding everything else.
  - The pacman cell is 0 unless it is a wall or a ghost's previous cell.
- Exactly N writes per sweep, each cell written once, in raster order. Addresses outside 0..COLS-1 / 0..ROWS-1 are never written.
- On the edge leaving DRAIN:
  - map_done=1 for exactly one cycle.
  - ready becomes 1 only if pending=0; otherwise ready stays 0 and IDLE restarts the sweep on the next edge.
- Mid-sweep position change: the current sweep runs to completion using the old snapshot and is not aborted. A rebuild follows immediately.
- ready stays 1 in IDLE until the edge entering the next SWEEP.
- Latency: from the edge entering SWEEP, ready rises N+1 cycles later (1201 with defaults).
- After reset release, the first sweep begins on the first rising edge.

Test Plan:
- Reset release, pacman (20,20), no walls, ghosts' previous cells at (16,13) and (23,13):
  - Exactly 1200 writes.
  - (0,0)=40; (39,29)=28; (20,20)=0; (16,13)=19; (23,13)=18.
  - ready=1 and a single map_done pulse at cycle 1201.
- wall_q=1 for cell (5,5) with pacman at (5,6) -> (5,5) written 255; (4,6)=1.
- Both ghosts' previous cells at (20,21), pacman at (20,20) -> (20,21)=17.
- Pacman moves from (20,20) to (21,20) at SWEEP cycle 600:
  - First sweep finishes using (20,20); map_done pulses; ready stays 0.
  - Second sweep starts the next cycle; ready=1 after it, with (21,20)=0.
- reset=0 asserted at SWEEP cycle 300:
  - wren, ready and map_done go 0 immediately (async).
  - After release, a full 1200-write sweep restarts from (0,0).
- start pulse while ready=1 and positions unchanged -> ready drops on the next edge and a full sweep re-runs with identical data.

Source files
------------

// File: rtl/ghost_dist_map_writer_if.sv
// ghost_dist_map_writer_if: positions in, wall ROM read port, map RAM write port and status out
interface ghost_dist_map_writer_if;
    logic       start;
    logic [5:0] curr_pacman_x;
    logic [4:0] curr_pacman_y;
    logic [5:0] prev_ghost1_x;
    logic [4:0] prev_ghost1_y;
    logic [5:0] prev_ghost2_x;
    logic [4:0] prev_ghost2_y;
    logic [5:0] wall_rdaddr_x;
    logic [4:0] wall_rdaddr_y;
    logic       wall_q;
    logic       wren;
    logic [5:0] wraddr_x;
    logic [4:0] wraddr_y;
    logic [7:0] wrdata;
    logic       ready;
    logic       map_done;
    modport master (
        output start, curr_pacman_x, curr_pacman_y, prev_ghost1_x, prev_ghost1_y,
               prev_ghost2_x, prev_ghost2_y, wall_q,
        input  wall_rdaddr_x, wall_rdaddr_y, wren, wraddr_x, wraddr_y, wrdata, ready, map_done
    );
    modport slave (
        input  start, curr_pacman_x, curr_pacman_y, prev_ghost1_x, prev_ghost1_y,
               prev_ghost2_x, prev_ghost2_y, wall_q,
        output wall_rdaddr_x, wall_rdaddr_y, wren, wraddr_x, wraddr_y, wrdata, ready, map_done
    );
endinterface

// File: rtl/ghost_dist_map_writer.sv
// ghost_dist_map_writer: sweeps the grid, writing Manhattan distance to pacman plus ghost-reverse penalty into the map RAM
module ghost_dist_map_writer #(
    parameter int COLS         = 40,
    parameter int ROWS         = 30,
    parameter int WALL_VAL     = 255,
    parameter int PREV_PENALTY = 8
) (
    input logic CLOCK_50,
    input logic reset,
    ghost_dist_map_writer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;
    localparam logic [5:0] X_LAST = 6'(COLS - 1);
    localparam logic [4:0] Y_LAST = 5'(ROWS - 1);
    localparam logic [8:0] PEN    = 9'(PREV_PENALTY);
    localparam logic [7:0] WALL   = 8'(WALL_VAL);
    state_t     state, state_nxt;
    logic       pending, pend_nxt, diff, last, wr_valid, ready, map_done;
    logic [5:0] x_cnt, wr_x, s_px, s_g1x, s_g2x, dx;
    logic [4:0] y_cnt, wr_y, s_py, s_g1y, s_g2y, dy;
    logic [8:0] sum;
    logic [7:0] cost;
    always_comb begin
        diff      = {bus.curr_pacman_x, bus.curr_pacman_y, bus.prev_ghost1_x, bus.prev_ghost1_y,
                     bus.prev_ghost2_x, bus.prev_ghost2_y} != {s_px, s_py, s_g1x, s_g1y, s_g2x, s_g2y};
        pend_nxt  = pending | bus.start | diff;
        last      = x_cnt == X_LAST && y_cnt == Y_LAST;
        state_nxt = state == IDLE ? (pend_nxt ? SWEEP : IDLE) :
                    state == SWEEP ? (last ? DRAIN : SWEEP) : IDLE;
    end
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pending  <= 1'b1;
            ready    <= 1'b0;
            map_done <= 1'b0;
            wr_valid <= 1'b0;
            {x_cnt, y_cnt, wr_x, wr_y} <= '0;
            {s_px, s_py, s_g1x, s_g1y, s_g2x, s_g2y} <= '0;
        end else begin
            state    <= state_nxt;
            map_done <= state == DRAIN;
            wr_valid <= state == SWEEP;
            if (state == SWEEP) begin
                wr_x  <= x_cnt;
                wr_y  <= y_cnt;
                x_cnt <= x_cnt == X_LAST ? 6'd0 : x_cnt + 6'd1;
                if (x_cnt == X_LAST) y_cnt <= last ? 5'd0 : y_cnt + 5'd1;
            end
            if (state == IDLE && pend_nxt) begin
                {s_px, s_py, s_g1x, s_g1y, s_g2x, s_g2y} <= {bus.curr_pacman_x, bus.curr_pacman_y,
                    bus.prev_ghost1_x, bus.prev_ghost1_y, bus.prev_ghost2_x, bus.prev_ghost2_y};
                pending <= 1'b0;
                ready   <= 1'b0;
            end else begin
                pending <= pend_nxt;
                // a change seen during the final cycle still invalidates the map
                if (state == DRAIN) ready <= !pend_nxt;
            end
        end
    end
    always_comb begin
        dx   = wr_x >= s_px ? wr_x - s_px : s_px - wr_x;
        dy   = wr_y >= s_py ? wr_y - s_py : s_py - wr_y;
        sum  = 9'(dx) + 9'(dy) + ({wr_x, wr_y} == {s_g1x, s_g1y} ? PEN : 9'd0)
                               + ({wr_x, wr_y} == {s_g2x, s_g2y} ? PEN : 9'd0);
        cost = bus.wall_q ? WALL : sum > 9'd254 ? 8'd254 : sum[7:0];
    end
    assign bus.wall_rdaddr_x = x_cnt;
    assign bus.wall_rdaddr_y = y_cnt;
    assign bus.wren          = wr_valid;
    assign bus.wraddr_x      = wr_x;
    assign bus.wraddr_y      = wr_y;
    assign bus.wrdata        = wr_valid ? cost : 8'd0;
    assign bus.ready         = ready;
    assign bus.map_done      = map_done;
endmodule

// File: tb/tb_ghost_dist_map_writer.sv
// tb_ghost_dist_map_writer: scoreboard bench; each expected sweep is queued up front, a monitor pops on every write
module tb_ghost_dist_map_writer;
    logic CLOCK_50 = 1'b0;
    logic reset = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;
    ghost_dist_map_writer_if bus();
    ghost_dist_map_writer dut (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus));

    typedef struct {int x; int y; int d;} wr_t;
    wr_t sb[$];
    wr_t mon_e;
    int checks = 0, errors = 0, writes = 0, dones = 0, cyc = 0, diffs = 0;
    bit wall_mem [0:63][0:31];
    logic [7:0] ram [0:63][0:31];
    logic [7:0] ram_copy [0:63][0:31];

    always @(posedge CLOCK_50) bus.wall_q <= wall_mem[bus.wall_rdaddr_x][bus.wall_rdaddr_y];

    always @(negedge CLOCK_50) if (reset) begin
        if (bus.map_done) dones++;
        if (bus.wren) begin
            writes++;
            ram[bus.wraddr_x][bus.wraddr_y] = bus.wrdata;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got (%0d,%0d)=%0d, want no write", bus.wraddr_x, bus.wraddr_y, bus.wrdata);
            end else begin
                mon_e = sb.pop_front();
                if (bus.wraddr_x != mon_e.x || bus.wraddr_y != mon_e.y || bus.wrdata != mon_e.d) begin
                    errors++;
                    $display("FAIL write: got (%0d,%0d)=%0d, want (%0d,%0d)=%0d",
                             bus.wraddr_x, bus.wraddr_y, bus.wrdata, mon_e.x, mon_e.y, mon_e.d);
                end
            end
        end
    end

    task automatic chk(input string n, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", n, got, want);
        end
    endtask

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    task automatic push_sweep(input int px, py, g1x, g1y, g2x, g2y);
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 40; x++) begin
                int d;
                d = iabs(x - px) + iabs(y - py);
                if (x == g1x && y == g1y) d += 8;
                if (x == g2x && y == g2y) d += 8;
                if (d > 254) d = 254;
                if (wall_mem[x][y]) d = 255;
                sb.push_back('{x, y, d});
            end
    endtask

    task automatic set_pos(input int px, py, g1x, g1y, g2x, g2y);
        bus.curr_pacman_x = 6'(px);
        bus.curr_pacman_y = 5'(py);
        bus.prev_ghost1_x = 6'(g1x);
        bus.prev_ghost1_y = 5'(g1y);
        bus.prev_ghost2_x = 6'(g2x);
        bus.prev_ghost2_y = 5'(g2y);
    endtask

    task automatic wait_level(input logic lvl, input string n, output int c);
        c = 0;
        while (bus.ready !== lvl && c < 3000) begin
            @(posedge CLOCK_50);
            #1;
            c++;
        end
        if (bus.ready !== lvl) begin
            checks++;
            errors++;
            $display("FAIL %s: ready never reached %0d (timeout)", n, lvl);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        set_pos(20, 20, 16, 13, 23, 13);
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_wren", bus.wren, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_done", bus.map_done, 0);
        chk("rst_wraddr", {bus.wraddr_x, bus.wraddr_y}, 0);
        chk("rst_rdaddr", {bus.wall_rdaddr_x, bus.wall_rdaddr_y}, 0);
        chk("rst_wrdata", bus.wrdata, 0);
        // first sweep: open maze
        push_sweep(20, 20, 16, 13, 23, 13);
        @(negedge CLOCK_50);
        reset = 1'b1;
        wait_level(1'b1, "first_ready", cyc);
        chk("latency", cyc - 1, 1201);
        chk("done_pulse", bus.map_done, 1);
        @(posedge CLOCK_50);
        #1;
        chk("done_low", bus.map_done, 0);
        chk("done_count", dones, 1);
        chk("writes1", writes, 1200);
        chk("sb_empty1", sb.size(), 0);
        chk("c_0_0", ram[0][0], 40);
        chk("c_39_29", ram[39][29], 28);
        chk("c_pac", ram[20][20], 0);
        chk("c_g1", ram[16][13], 19);
        chk("c_g2", ram[23][13], 18);
        // wall next to pacman
        wall_mem[5][5] = 1'b1;
        writes = 0;
        push_sweep(5, 6, 16, 13, 23, 13);
        set_pos(5, 6, 16, 13, 23, 13);
        wait_level(1'b0, "wall_drop", cyc);
        wait_level(1'b1, "wall_ready", cyc);
        chk("wall_5_5", ram[5][5], 255);
        chk("c_4_6", ram[4][6], 1);
        chk("writes2", writes, 1200);
        // both ghosts on the same cell
        push_sweep(20, 20, 20, 21, 20, 21);
        set_pos(20, 20, 20, 21, 20, 21);
        wait_level(1'b0, "dbl_drop", cyc);
        wait_level(1'b1, "dbl_ready", cyc);
        chk("dbl_20_21", ram[20][21], 17);
        chk("dbl_pac", ram[20][20], 0);
        // pacman moves mid-sweep
        writes = 0;
        dones = 0;
        push_sweep(20, 20, 20, 21, 20, 21);
        pulse_start();
        chk("mid_ready_drop", bus.ready, 0);
        repeat (600) @(posedge CLOCK_50);
        #1;
        push_sweep(21, 20, 20, 21, 20, 21);
        set_pos(21, 20, 20, 21, 20, 21);
        cyc = 0;
        while (!bus.map_done && cyc < 3000) begin
            @(posedge CLOCK_50);
            #1;
            cyc++;
        end
        chk("mid_done_seen", bus.map_done, 1);
        chk("mid_stale_ready", bus.ready, 0);
        chk("mid_writes_a", writes, 1200);
        @(posedge CLOCK_50);
        #1;
        chk("mid_idle_ready", bus.ready, 0);
        @(posedge CLOCK_50);
        #1;
        chk("mid_restart_wren", bus.wren, 1);
        wait_level(1'b1, "mid_ready", cyc);
        chk("mid_pac", ram[21][20], 0);
        chk("mid_writes", writes, 2400);
        chk("mid_sb_empty", sb.size(), 0);
        // reset in the middle of a sweep
        push_sweep(21, 20, 20, 21, 20, 21);
        pulse_start();
        repeat (300) @(posedge CLOCK_50);
        #1;
        chk("pre_rst_wren", bus.wren, 1);
        reset = 1'b0;
        #1;
        chk("arst_wren", bus.wren, 0);
        chk("arst_ready", bus.ready, 0);
        chk("arst_done", bus.map_done, 0);
        chk("arst_wraddr", {bus.wraddr_x, bus.wraddr_y}, 0);
        sb.delete();
        repeat (2) @(posedge CLOCK_50);
        writes = 0;
        push_sweep(21, 20, 20, 21, 20, 21);
        @(negedge CLOCK_50);
        reset = 1'b1;
        wait_level(1'b1, "arst_ready_after", cyc);
        chk("arst_latency", cyc - 1, 1201);
        chk("arst_writes", writes, 1200);
        chk("arst_sb_empty", sb.size(), 0);
        // start with unchanged positions rebuilds identical data
        for (int x = 0; x < 40; x++)
            for (int y = 0; y < 30; y++) ram_copy[x][y] = ram[x][y];
        writes = 0;
        push_sweep(21, 20, 20, 21, 20, 21);
        pulse_start();
        chk("start_ready_drop", bus.ready, 0);
        wait_level(1'b1, "start_ready", cyc);
        diffs = 0;
        for (int x = 0; x < 40; x++)
            for (int y = 0; y < 30; y++) if (ram_copy[x][y] !== ram[x][y]) diffs++;
        chk("start_same_map", diffs, 0);
        chk("start_writes", writes, 1200);
        chk("start_sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
